// File: rtl/maxpool_pkg.sv
// Shared definitions for the max-pool / max-unpool pair.
package maxpool_pkg;

    localparam int unsigned DATA_W_DEF = 32;

    // IEEE-754 single-precision +0.0 fill value
    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

    // Argmax position encodings inside a 2x2 window, shared with the pooling stage
    localparam logic [1:0] IDX_TL = 2'd0;
    localparam logic [1:0] IDX_TR = 2'd1;
    localparam logic [1:0] IDX_BL = 2'd2;
    localparam logic [1:0] IDX_BR = 2'd3;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        EMIT_TOP = 2'd1,
        EMIT_BOT = 2'd2
    } unpool_state_e;

    // Window slot addressed by output row half (bottom) and column parity (right)
    function automatic logic [1:0] slot_idx(input logic bottom, input logic right);
        return {bottom, right};
    endfunction

    // Counter width helper: ceil(log2(v)) with a 1-bit floor
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/unpool_row_buf.sv
// One pooled row of {idx, data} entries: synchronous write, combinational read.
module unpool_row_buf
    import maxpool_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 34,
    parameter int unsigned AW    = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: contents are intentionally left untouched by reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: address is always < DEPTH by construction of the counters
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/max_unpool_2x2.sv
// 2x2 max-unpool: buffers one pooled row, then replays it as two upsampled rows.
module max_unpool_2x2
    import maxpool_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned POOL_W = 4,
    parameter int unsigned POOL_H = 4
) (
    input  logic              clk,
    input  logic              enable,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_idx,
    output logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              frame_done
);

    localparam int unsigned COL_W  = clog2_min1(POOL_W);
    localparam int unsigned OCOL_W = clog2_min1(2 * POOL_W);
    localparam int unsigned ROW_W  = clog2_min1(POOL_H);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(POOL_W - 1);
    localparam logic [OCOL_W-1:0] OCOL_LAST = OCOL_W'(2 * POOL_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(POOL_H - 1);

    unpool_state_e     state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [OCOL_W-1:0] ocol_q, ocol_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              frame_done_q, frame_done_d;

    logic                in_xfer;
    logic                out_xfer;
    logic [COL_W-1:0]    rd_addr;
    logic [DATA_W+1:0]   rd_entry;

    // Handshake outputs depend only on registered state and the reset input
    always_comb begin
        ready_in  = enable && (state_q == LOAD);
        valid_out = enable && (state_q != LOAD);
        in_xfer   = valid_in && ready_in;
        out_xfer  = valid_out && out_ready;
    end

    assign rd_addr = COL_W'(ocol_q >> 1);

    unpool_row_buf #(
        .DEPTH (POOL_W),
        .WIDTH (DATA_W + 2),
        .AW    (COL_W)
    ) u_row_buf (
        .clk_i   (clk),
        .we_i    (in_xfer),
        .waddr_i (col_q),
        .wdata_i ({in_idx, in_data}),
        .raddr_i (rd_addr),
        .rdata_o (rd_entry)
    );

    // Element goes to its argmax slot; the other three slots carry +0.0
    always_comb begin
        if (rd_entry[DATA_W +: 2] == slot_idx(state_q == EMIT_BOT, ocol_q[0])) begin
            out_data = rd_entry[DATA_W-1:0];
        end else begin
            out_data = DATA_W'(FP_POS_ZERO);
        end
    end

    // Next-state logic for the load / emit-top / emit-bottom sequence
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        ocol_d       = ocol_q;
        row_d        = row_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (in_xfer) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = EMIT_TOP;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            EMIT_TOP: begin
                if (out_xfer) begin
                    if (ocol_q == OCOL_LAST) begin
                        ocol_d  = '0;
                        state_d = EMIT_BOT;
                    end else begin
                        ocol_d = ocol_q + OCOL_W'(1);
                    end
                end
            end
            EMIT_BOT: begin
                if (out_xfer) begin
                    if (ocol_q == OCOL_LAST) begin
                        ocol_d  = '0;
                        state_d = LOAD;
                        if (row_q == ROW_LAST) begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        ocol_d = ocol_q + OCOL_W'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!enable) begin
            state_q      <= LOAD;
            col_q        <= '0;
            ocol_q       <= '0;
            row_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            ocol_q       <= ocol_d;
            row_q        <= row_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_unpool_2x2.sv
// Directed bench for max_unpool_2x2 with POOL_W=2, POOL_H=2.
module tb_max_unpool_2x2;

    logic        clk = 1'b0;
    logic        enable;
    logic        valid_in;
    logic [31:0] in_data;
    logic [1:0]  in_idx;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] out_data;
    logic        out_ready;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_v [0:7];

    max_unpool_2x2 #(
        .DATA_W (32),
        .POOL_W (2),
        .POOL_H (2)
    ) dut (
        .clk        (clk),
        .enable     (enable),
        .valid_in   (valid_in),
        .in_data    (in_data),
        .in_idx     (in_idx),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one element and wait (bounded) until it is taken
    task automatic send_one(input string tag, input logic [31:0] d, input logic [1:0] idx);
        int k;
        valid_in = 1'b1;
        in_data  = d;
        in_idx   = idx;
        k = 0;
        while (ready_in !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk({tag, "_ready"}, {31'b0, ready_in}, 32'd1);
        tick();
    endtask

    // Drain one upsampled row pair against exp_v; optionally stall 3 cycles at element stall_at
    task automatic recv_row(input string tag, input int stall_at);
        int k;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            k = 0;
            while (valid_out !== 1'b1 && k < 40) begin
                tick();
                k++;
            end
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk($sformatf("%s_stall_vld%0d", tag, s), {31'b0, valid_out}, 32'd1);
                    chk($sformatf("%s_stall_dat%0d", tag, s), out_data, exp_v[i]);
                end
                out_ready = 1'b1;
            end
            chk($sformatf("%s[%0d]", tag, i), out_data, exp_v[i]);
            tick();
        end
        chk({tag, "_vld_after"}, {31'b0, valid_out}, 32'd0);
    endtask

    initial begin
        enable    = 1'b0;
        valid_in  = 1'b0;
        in_data   = '0;
        in_idx    = '0;
        out_ready = 1'b0;

        // Reset
        tick();
        tick();
        chk("rst_ready", {31'b0, ready_in}, 32'd0);
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_fdone", {31'b0, frame_done}, 32'd0);
        enable = 1'b1;
        #1;
        chk("post_rst_ready", {31'b0, ready_in}, 32'd1);
        chk("post_rst_valid", {31'b0, valid_out}, 32'd0);

        // Row A: basic placement and one-cycle latency
        send_one("A0", 32'h3F80_0000, 2'd0);
        send_one("A1", 32'h4000_0000, 2'd3);
        valid_in = 1'b0;
        chk("A_latency_vld", {31'b0, valid_out}, 32'd1);
        chk("A_emit_ready", {31'b0, ready_in}, 32'd0);
        exp_v = '{32'h3F80_0000, 32'h0, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h4000_0000};
        recv_row("A", -1);
        chk("A_fdone", {31'b0, frame_done}, 32'd0);

        // Row B: sign and -0.0, closes frame 1
        send_one("B0", 32'hC040_0000, 2'd1);
        send_one("B1", 32'h8000_0000, 2'd2);
        valid_in = 1'b0;
        exp_v = '{32'h0, 32'hC040_0000, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h8000_0000, 32'h0};
        recv_row("B", -1);
        chk("B_fdone_pulse", {31'b0, frame_done}, 32'd1);
        chk("B_next_ready", {31'b0, ready_in}, 32'd1);
        tick();
        chk("B_fdone_clear", {31'b0, frame_done}, 32'd0);

        // Row C: backpressure at top element 2, with new input held during emission
        send_one("C0", 32'h4040_0000, 2'd3);
        send_one("C1", 32'h4080_0000, 2'd0);
        valid_in = 1'b1;
        in_data  = 32'h4100_0000;
        in_idx   = 2'd1;
        chk("C_emit_ready", {31'b0, ready_in}, 32'd0);
        exp_v = '{32'h0, 32'h0, 32'h4080_0000, 32'h0,
                  32'h0, 32'h4040_0000, 32'h0, 32'h0};
        recv_row("C", 2);
        chk("C_fdone", {31'b0, frame_done}, 32'd0);
        chk("C_load_ready", {31'b0, ready_in}, 32'd1);

        // Row D: the held element is taken on the first LOAD cycle
        send_one("D0", 32'h4100_0000, 2'd1);
        send_one("D1", 32'h4110_0000, 2'd2);
        valid_in = 1'b0;
        exp_v = '{32'h0, 32'h4100_0000, 32'h0, 32'h0,
                  32'h0, 32'h0, 32'h4110_0000, 32'h0};
        recv_row("D", -1);
        chk("D_fdone_pulse", {31'b0, frame_done}, 32'd1);
        tick();
        chk("D_fdone_clear", {31'b0, frame_done}, 32'd0);

        // Row E: reset in the middle of the top row
        send_one("E0", 32'h3F80_0000, 2'd0);
        send_one("E1", 32'h4000_0000, 2'd3);
        valid_in  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        enable = 1'b0;
        #1;
        chk("E_rst_ready", {31'b0, ready_in}, 32'd0);
        chk("E_rst_valid", {31'b0, valid_out}, 32'd0);
        tick();
        enable = 1'b1;
        #1;
        chk("E_after_valid", {31'b0, valid_out}, 32'd0);
        chk("E_after_ready", {31'b0, ready_in}, 32'd1);

        // Row F: fresh row after reset is row 0 of a new frame
        send_one("F0", 32'h4120_0000, 2'd2);
        send_one("F1", 32'h3F00_0000, 2'd1);
        valid_in = 1'b0;
        exp_v = '{32'h0, 32'h0, 32'h0, 32'h3F00_0000,
                  32'h4120_0000, 32'h0, 32'h0, 32'h0};
        recv_row("F", -1);
        chk("F_fdone", {31'b0, frame_done}, 32'd0);

        // Row G: NaN payload and denormal, closes the frame
        send_one("G0", 32'h7FC0_0001, 2'd3);
        send_one("G1", 32'h0000_0001, 2'd0);
        valid_in = 1'b0;
        exp_v = '{32'h0, 32'h0, 32'h0000_0001, 32'h0,
                  32'h0, 32'h7FC0_0001, 32'h0, 32'h0};
        recv_row("G", -1);
        chk("G_fdone_pulse", {31'b0, frame_done}, 32'd1);
        tick();
        chk("G_fdone_clear", {31'b0, frame_done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
